um245r_ctrl: RTL and testbench
==============================

UM245R_CTRL -- requirements
Module: um245r_ctrl

Interface
REQ-001 SHALL have parameter T_SETUP, default 2, number of clk cycles D is driven with WR high before WR falls (covers T9 = 20ns).
REQ-002 SHALL have parameter T_HOLD, default 1, number of clk cycles D stays driven after WR falls (covers T10).
REQ-003 SHALL have parameter T_RDDATA, default 2, number of clk cycles after _RD falls before D is sampled (covers T3 max).
REQ-004 SHALL have parameter T_RDLOW, default 5, total number of clk cycles _RD is held low (covers T1 = 50ns); T_RDLOW > T_RDDATA.
REQ-005 SHALL have parameter T_GAP, default 3, recovery cycles after any transfer before flags are resampled.
REQ-006 SHALL have one clock and a synchronous, active-high reset.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 tx_data  input  8  byte to transmit.
REQ-010 tx_valid  input  1  requester has a byte.
REQ-011 tx_ready  output  1  controller accepts tx_data this cycle.
REQ-012 rx_data  output  8  received byte.
REQ-013 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-014 rx_ready  input  1  consumer takes rx_data this cycle.
REQ-015 D  inout  8  um245r data bus; driven only in TX_SETUP/TX_HOLD, else high-Z.
REQ-016 WR  output  1  um245r write strobe; device latches on falling edge.
REQ-017 _RD  output  1  um245r read strobe, active low.
REQ-018 _TXE  input  1  asynchronous; low = device can accept a byte.
REQ-019 _RXF  input  1  asynchronous; low = device has a byte.

Function
REQ-020 _TXE and _RXF SHALL pass through 2-flop synchronisers; all decisions use the synchronised values (txe_ok, rxf_ok, both active high).
REQ-021 States SHALL be IDLE, TX_SETUP, TX_HOLD, RX_WAIT, RX_LOW, GAP; one cycle counter shared by all timed states.
REQ-022 tx_ready SHALL equal (state==IDLE && txe_ok && !(rx_eligible && last_was_tx)), where rx_eligible = rxf_ok && !rx_valid.
REQ-023 In IDLE: tx_valid&&tx_ready -> capture tx_data, WR=1, go TX_SETUP; else rx_eligible -> _RD=0, go RX_WAIT; else stay.
REQ-024 Arbitration when both eligible: round-robin via last_was_tx flag; after reset, TX wins first.
REQ-025 TX_SETUP SHALL drive captured byte on D for T_SETUP cycles with WR=1, then drive WR=0 and go TX_HOLD.
REQ-026 TX_HOLD SHALL keep D driven for T_HOLD cycles, then release D, set WR=1, set last_was_tx=1, go GAP.
REQ-027 Latency: WR falls exactly T_SETUP+1 cycles after the tx accept edge.
REQ-028 RX_WAIT SHALL keep _RD=0 for T_RDDATA cycles, then register D into rx_data and go RX_LOW.
REQ-029 RX_LOW SHALL keep _RD=0 until T_RDLOW total low cycles elapse, then raise _RD, set rx_valid=1, set last_was_tx=0, go GAP.
REQ-030 GAP SHALL wait T_GAP cycles with all strobes inactive, then return to IDLE (prevents acting on stale synchronised flags).
REQ-031 rx_valid SHALL clear on rx_valid&&rx_ready; a new read SHALL NOT start while rx_valid=1 (single-entry buffer, no overwrite).
REQ-032 rx_valid clearing and a read start in the same IDLE cycle SHALL NOT both occur; the read starts next cycle.
REQ-033 _TXE or _RXF changing mid-transfer SHALL NOT abort or alter the transfer in progress.
REQ-034 WR and _RD SHALL never be active simultaneously; D SHALL never be driven while _RD=0.

Reset
REQ-035 On reset: state=IDLE, WR=1, _RD=1, D high-Z, tx_ready=0 during reset, rx_valid=0, rx_data=0, last_was_tx=0, counter=0, synchronisers=inactive (high).
REQ-036 Reset asserted mid-transfer SHALL take effect next edge; the partial byte is discarded.

Structure
REQ-037 State enum and default timing constants SHALL live in shared package um245r_pkg.
REQ-038 One sub-module, sync2 (2-flop synchroniser), SHALL be instantiated per asynchronous flag.

Verification (bench uses um245r model, defaults, 10ns clk)
REQ-039 Single tx: tx_data=8'h41, _TXE low -> WR falls 3 cycles after accept, D=8'h41 on that edge, D high-Z 1 cycle later.
REQ-040 Single rx: model holds 8'h21, _RXF falls -> _RD low exactly 5 cycles, rx_data=8'h21, rx_valid=1 at _RD rise.
REQ-041 Contention: tx_valid and _RXF both pending continuously -> transfers alternate TX,RX,TX,RX.
REQ-042 Backpressure: rx_ready=0 with two bytes queued -> one read only, rx_valid held, second read starts one cycle after rx_ready pulse.
REQ-043 Reset asserted in TX_SETUP -> next edge WR=1, _RD=1, D high-Z, no WR falling edge.
REQ-044 Stream 256 tx bytes 0..255 -> model receives all in order, no WR/_RD overlap.

Source files
------------

// File: rtl/um245r_pkg.sv
// Shared definitions for the UM245R FIFO controller: FSM states, counter type
// and default strobe timing in clk cycles.
package um245r_pkg;

  localparam int unsigned T_SETUP_DEF  = 2;
  localparam int unsigned T_HOLD_DEF   = 1;
  localparam int unsigned T_RDDATA_DEF = 2;
  localparam int unsigned T_RDLOW_DEF  = 5;
  localparam int unsigned T_GAP_DEF    = 3;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    TX_SETUP,
    TX_HOLD,
    RX_WAIT,
    RX_LOW,
    GAP
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous level; resets to RESET_VAL so
// an active-low flag reads as inactive while the block is in reset.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // NOTE: non-blocking assignments make both flops sample on the same edge,
  // so the chain is really two stages deep instead of collapsing into one.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/um245r_ctrl.sv
// UM245R parallel FIFO controller: valid/ready byte streams on the fabric side,
// WR/_RD strobes and a shared tristate data bus on the device side.
module um245r_ctrl
  import um245r_pkg::*;
#(
  parameter int unsigned T_SETUP  = T_SETUP_DEF,
  parameter int unsigned T_HOLD   = T_HOLD_DEF,
  parameter int unsigned T_RDDATA = T_RDDATA_DEF,
  parameter int unsigned T_RDLOW  = T_RDLOW_DEF,
  parameter int unsigned T_GAP    = T_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  inout  wire  [7:0] D,
  output logic       WR,
  output logic       _RD,
  input  logic       _TXE,
  input  logic       _RXF
);

  state_t     state;
  cnt_t       cnt;
  logic [7:0] tx_byte;
  logic       d_oe;
  logic       last_was_tx;
  logic       txe_sync;
  logic       rxf_sync;
  logic       txe_ok;
  logic       rxf_ok;
  logic       rx_eligible;

  sync2 #(.RESET_VAL(1'b1)) u_sync_txe (
    .clk      (clk),
    .reset    (reset),
    .async_in (_TXE),
    .sync_out (txe_sync)
  );

  sync2 #(.RESET_VAL(1'b1)) u_sync_rxf (
    .clk      (clk),
    .reset    (reset),
    .async_in (_RXF),
    .sync_out (rxf_sync)
  );

  assign txe_ok      = !txe_sync;
  assign rxf_ok      = !rxf_sync;
  assign rx_eligible = rxf_ok && !rx_valid;

  // Round-robin: a pending read outranks a write only when the last transfer was a write.
  assign tx_ready = !reset && (state == IDLE) && txe_ok && !(rx_eligible && last_was_tx);

  assign D = d_oe ? tx_byte : 8'hzz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      tx_byte     <= '0;
      d_oe        <= 1'b0;
      WR          <= 1'b1;
      _RD         <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      last_was_tx <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (tx_valid && tx_ready) begin
            tx_byte <= tx_data;
            WR      <= 1'b1;
            state   <= TX_SETUP;
          end else if (rx_eligible) begin
            _RD   <= 1'b0;
            state <= RX_WAIT;
          end
        end

        // D goes out one cycle after accept, giving exactly T_SETUP cycles before WR falls.
        TX_SETUP: begin
          d_oe <= 1'b1;
          if (cnt == CNT_W'(T_SETUP)) begin
            WR    <= 1'b0;
            cnt   <= '0;
            state <= TX_HOLD;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        TX_HOLD: begin
          if (cnt == CNT_W'(T_HOLD - 1)) begin
            d_oe        <= 1'b0;
            WR          <= 1'b1;
            last_was_tx <= 1'b1;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        // The counter keeps running across RX_WAIT and RX_LOW to time the total _RD pulse.
        RX_WAIT: begin
          if (cnt == CNT_W'(T_RDDATA - 1)) begin
            rx_data <= D;
            state   <= RX_LOW;
          end
          cnt <= cnt + cnt_t'(1);
        end

        RX_LOW: begin
          if (cnt == CNT_W'(T_RDLOW - 1)) begin
            _RD         <= 1'b1;
            rx_valid    <= 1'b1;
            last_was_tx <= 1'b0;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        GAP: begin
          if (cnt == CNT_W'(T_GAP - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_um245r_ctrl.sv
// Scoreboard bench for um245r_ctrl against a behavioural UM245R model with
// default timing and a 10-unit clock.
module tb_um245r_ctrl;

  localparam int  T_SETUP = 2;
  localparam int  T_RDLOW = 5;
  localparam byte K_TX    = "T";
  localparam byte K_RX    = "R";

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  wire  [7:0] d_bus;
  logic       wr;
  logic       rd_n;
  logic       txe_n;
  logic       rxf_n;

  logic       model_oe;
  logic [7:0] model_byte;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] tx_src_q[$];
  logic [7:0] rx_fifo[$];
  int         acc_edge_q[$];
  byte        kind_log[$];

  int wr_fall_cnt  = 0;
  int rd_fall_cnt  = 0;
  int rd_fall_edge = 0;

  um245r_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .D        (d_bus),
    .WR       (wr),
    ._RD      (rd_n),
    ._TXE     (txe_n),
    ._RXF     (rxf_n)
  );

  assign d_bus = model_oe ? model_byte : 8'hzz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // UM245R device model: serves queued bytes on _RD, raises _RXF when empty.
  initial begin
    model_oe   = 1'b0;
    model_byte = 8'h00;
    rxf_n      = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (model_oe && rd_n) begin
        void'(rx_fifo.pop_front());
        model_oe = 1'b0;
      end else if (!model_oe && !rd_n && rx_fifo.size() > 0) begin
        model_byte = rx_fifo[0];
        model_oe   = 1'b1;
      end
      rxf_n = (rx_fifo.size() == 0);
    end
  end

  // Monitor: samples on the falling clock edge and pops the scoreboard.
  initial begin
    logic prev_wr = 1'b1;
    logic prev_rd = 1'b1;
    logic hold_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("no_wr_rd_overlap", {31'd0, (!wr && !rd_n)}, 32'd0);
        if (!rd_n) check("d_released_in_read", {31'd0, dut.d_oe}, 32'd0);
        if (model_oe) check("d_bus_read_value", {24'd0, d_bus}, {24'd0, model_byte});
        if (tx_valid && tx_ready) acc_edge_q.push_back(cyc + 1);

        if (hold_pending) begin
          check("tx_d_release", {31'd0, dut.d_oe}, 32'd0);
          hold_pending = 1'b0;
        end
        if (prev_wr && !wr) begin
          wr_fall_cnt++;
          kind_log.push_back(K_TX);
          if (exp_tx_q.size() == 0) check("tx_unexpected_byte", {24'd0, d_bus}, 32'hFFFF_FFFF);
          else check("tx_data_at_wr_fall", {24'd0, d_bus}, {24'd0, exp_tx_q.pop_front()});
          if (acc_edge_q.size() == 0) check("tx_accept_recorded", 0, 1);
          else check("tx_wr_latency", cyc - acc_edge_q.pop_front(), T_SETUP + 1);
          hold_pending = 1'b1;
        end

        if (prev_rd && !rd_n) begin
          rd_fall_cnt++;
          rd_fall_edge = cyc;
        end
        if (!prev_rd && rd_n) begin
          kind_log.push_back(K_RX);
          check("rd_low_cycles", cyc - rd_fall_edge, T_RDLOW);
          check("rx_valid_at_rd_rise", {31'd0, rx_valid}, 32'd1);
          if (exp_rx_q.size() > 0) check("rx_data_at_rd_rise", {24'd0, rx_data}, {24'd0, exp_rx_q[0]});
        end

        if (rx_valid && rx_ready) begin
          if (exp_rx_q.size() == 0) check("rx_unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
          else check("rx_data_handshake", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
        end
      end else begin
        hold_pending = 1'b0;
      end
      prev_wr = wr;
      prev_rd = rd_n;
    end
  end

  // Offers every byte in tx_src_q in order, holding tx_valid until each is accepted.
  task automatic run_tx();
    int wait_cyc;
    while (tx_src_q.size() > 0) begin
      tx_data  = tx_src_q[0];
      tx_valid = 1'b1;
      wait_cyc = 0;
      do begin
        @(negedge clk);
        wait_cyc++;
      end while (!tx_ready && wait_cyc < 200);
      if (!tx_ready) begin
        check("tx_accept_timeout", 0, 1);
        tx_src_q.delete();
      end else begin
        @(posedge clk);
        #1;
        void'(tx_src_q.pop_front());
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n = 0;
    while ((exp_tx_q.size() > 0 || exp_rx_q.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_tx_q.size() + exp_rx_q.size(), 0);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int fall0;
    int rd0;
    int hs_edge;
    int n;
    byte exp_kind[4];
    exp_kind = '{K_TX, K_RX, K_TX, K_RX};

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b1;
    txe_n    = 1'b0;

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_wr", {31'd0, wr}, 32'd1);
    check("reset_rd_n", {31'd0, rd_n}, 32'd1);
    check("reset_d_released", {31'd0, dut.d_oe}, 32'd0);
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single write of 0x41
    exp_tx_q.push_back(8'h41);
    tx_src_q.push_back(8'h41);
    run_tx();
    wait_drained("single_tx", 100);

    // Single read of 0x21
    @(posedge clk);
    #1;
    exp_rx_q.push_back(8'h21);
    rx_fifo.push_back(8'h21);
    wait_drained("single_rx", 100);

    // Reset while in TX_SETUP
    @(posedge clk);
    #1;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    check("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
    fall0 = wr_fall_cnt;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_wr", {31'd0, wr}, 32'd1);
    check("rst_mid_rd_n", {31'd0, rd_n}, 32'd1);
    check("rst_mid_d_released", {31'd0, dut.d_oe}, 32'd0);
    check("rst_mid_tx_ready_low", {31'd0, tx_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    check("rst_mid_no_wr_fall", wr_fall_cnt - fall0, 0);
    acc_edge_q.delete();

    // Contention straight out of reset: both flags become valid together
    #1;
    reset = 1'b1;
    rx_fifo.push_back(8'hA1);
    rx_fifo.push_back(8'hA2);
    exp_rx_q.push_back(8'hA1);
    exp_rx_q.push_back(8'hA2);
    tx_src_q.push_back(8'h11);
    tx_src_q.push_back(8'h12);
    exp_tx_q.push_back(8'h11);
    exp_tx_q.push_back(8'h12);
    kind_log.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run_tx();
    wait_drained("contention", 200);
    check("contention_transfers", kind_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < kind_log.size()) check($sformatf("contention_order_%0d", i), {24'd0, kind_log[i]}, {24'd0, exp_kind[i]});
    end

    // Backpressure: two bytes queued, consumer stalled
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    rd0      = rd_fall_cnt;
    rx_fifo.push_back(8'hB1);
    rx_fifo.push_back(8'hB2);
    exp_rx_q.push_back(8'hB1);
    exp_rx_q.push_back(8'hB2);
    repeat (40) @(posedge clk);
    #1;
    check("bp_single_read", rd_fall_cnt - rd0, 1);
    check("bp_rx_valid_held", {31'd0, rx_valid}, 32'd1);
    check("bp_rx_data_held", {24'd0, rx_data}, 32'hB1);
    rx_ready = 1'b1;
    hs_edge  = cyc + 1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    n = 0;
    while (rd_fall_cnt - rd0 < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_second_read_started", rd_fall_cnt - rd0, 2);
    check("bp_second_read_edge", rd_fall_edge, hs_edge + 1);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    wait_drained("backpressure", 100);

    // Stream of 256 bytes
    @(posedge clk);
    #1;
    fall0 = wr_fall_cnt;
    for (int i = 0; i < 256; i++) begin
      tx_src_q.push_back(8'(i));
      exp_tx_q.push_back(8'(i));
    end
    run_tx();
    wait_drained("stream", 400);
    check("stream_wr_count", wr_fall_cnt - fall0, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
